// File: rtl/axil_req_arbiter.sv
// Round-robin share of one AXI-Lite master among NUM_REQ requesters, one transaction in flight; 3-cycle accept-to-rsp latency on a zero-wait slave.
// Backpressure: req_ready only in IDLE for the selected requester; waits indefinitely on every AXI ready/valid.
module axil_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_W-1:0]             m_axil_awaddr,
  output logic [2:0]                    m_axil_awprot,
  output logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  output logic [DATA_W-1:0]             m_axil_wdata,
  output logic [DATA_W/8-1:0]           m_axil_wstrb,
  output logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  input  logic [1:0]                    m_axil_bresp,
  input  logic                          m_axil_bvalid,
  output logic                          m_axil_bready,
  output logic [ADDR_W-1:0]             m_axil_araddr,
  output logic [2:0]                    m_axil_arprot,
  output logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  input  logic [DATA_W-1:0]             m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  output logic                          m_axil_rready
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_W / 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_AD   = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]         r_state;
  logic [IW-1:0]      r_ptr;
  logic               r_ptr_vld;
  logic [IW-1:0]      r_gnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic [1:0]         r_rsp_resp;
  logic [ADDR_W-1:0]  r_awaddr;
  logic               r_awvalid;
  logic [DATA_W-1:0]  r_wdata;
  logic [SW-1:0]      r_wstrb;
  logic               r_wvalid;
  logic               r_bready;
  logic [ADDR_W-1:0]  r_araddr;
  logic               r_arvalid;
  logic               r_rready;

  logic [IW-1:0]      w_start;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_win;
  logic               w_found;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_aw_done;
  logic               w_w_done;

  // Until the first grant nobody is "last", so the scan starts at requester 0.
  assign w_start = !r_ptr_vld ? '0 :
                   (int'(r_ptr) == NUM_REQ - 1) ? '0 : r_ptr + 1'b1;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((int'(w_start) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_req_ready = '0;
    if (r_state == S_IDLE && w_found) w_req_ready[w_win] = 1'b1;
  end

  assign w_gnt_oh  = NUM_REQ'(1) << r_gnt;
  assign w_aw_done = !r_awvalid || m_axil_awready;
  assign w_w_done  = !r_wvalid  || m_axil_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_ptr_vld   <= 1'b0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt     <= w_win;
            r_ptr     <= w_win;
            r_ptr_vld <= 1'b1;
            if (req_write[w_win]) begin
              r_awaddr  <= req_addr[w_win*ADDR_W +: ADDR_W];
              r_wdata   <= req_wdata[w_win*DATA_W +: DATA_W];
              r_wstrb   <= req_wstrb[w_win*SW +: SW];
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_AD;
            end else begin
              r_araddr  <= req_addr[w_win*ADDR_W +: ADDR_W];
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR_AD: begin
          // AW and W retire independently; move on once both have handshaked.
          if (m_axil_awready) r_awvalid <= 1'b0;
          if (m_axil_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axil_bvalid) begin
            r_rsp_resp  <= m_axil_bresp;
            r_rsp_rdata <= '0;
            r_bready    <= 1'b0;
            r_rsp_valid <= w_gnt_oh;
            r_state     <= S_RESP;
          end
        end
        S_RD_ADDR: begin
          if (m_axil_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axil_rvalid) begin
            r_rsp_rdata <= m_axil_rdata;
            r_rsp_resp  <= m_axil_rresp;
            r_rready    <= 1'b0;
            r_rsp_valid <= w_gnt_oh;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = w_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_resp       = r_rsp_resp;
  assign m_axil_awaddr  = r_awaddr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_bready  = r_bready;
  assign m_axil_araddr  = r_araddr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Bench for axil_req_arbiter: directed cases then random traffic against a round-robin model and a delay-programmable AXI-Lite slave.
module tb_axil_req_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*SW-1:0]   req_wstrb;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     m_axil_awaddr, m_axil_araddr;
  logic [2:0]        m_axil_awprot, m_axil_arprot;
  logic              m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [DW-1:0]     m_axil_wdata, m_axil_rdata;
  logic [SW-1:0]     m_axil_wstrb;
  logic [1:0]        m_axil_bresp, m_axil_rresp;
  logic              m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic              m_axil_rvalid, m_axil_rready;

  always #5 clk = ~clk;

  axil_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave programming (written by the main sequence only).
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_v = 2'b00, r_resp_v = 2'b00;
  logic [31:0] r_data_v = 32'h0;

  // Slave observations (each written by exactly one slave process).
  int            aw_cyc = 0, w_cyc = 0, r_cyc = 0, b_early = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [SW-1:0] cap_wstrb = '0;

  int last_gnt = N - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester after the last-granted one.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int r;
    r = -1;
    for (int k = 1; k <= N; k++)
      if (r < 0 && v[(last + k) % N]) r = (last + k) % N;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  initial begin : slv_aw
    int cnt;
    cnt = 0;
    m_axil_awready = 1'b0;
    forever begin
      @(negedge clk);
      m_axil_awready = 1'b0;
      if (m_axil_awvalid) begin
        aw_cyc++;
        if (cnt >= aw_dly) begin m_axil_awready = 1'b1; cap_awaddr = m_axil_awaddr; end
        cnt++;
      end else cnt = 0;
    end
  end

  initial begin : slv_w
    int cnt;
    cnt = 0;
    m_axil_wready = 1'b0;
    forever begin
      @(negedge clk);
      m_axil_wready = 1'b0;
      if (m_axil_wvalid) begin
        w_cyc++;
        if (cnt >= w_dly) begin
          m_axil_wready = 1'b1; cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
        end
        cnt++;
      end else cnt = 0;
    end
  end

  initial begin : slv_b
    int cnt;
    cnt = 0;
    m_axil_bvalid = 1'b0;
    m_axil_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      m_axil_bvalid = 1'b0;
      if (m_axil_bready && (m_axil_awvalid || m_axil_wvalid)) b_early++;
      if (m_axil_bready) begin
        if (cnt >= b_dly) begin m_axil_bvalid = 1'b1; m_axil_bresp = b_resp_v; end
        cnt++;
      end else cnt = 0;
    end
  end

  initial begin : slv_ar
    int cnt;
    cnt = 0;
    m_axil_arready = 1'b0;
    forever begin
      @(negedge clk);
      m_axil_arready = 1'b0;
      if (m_axil_arvalid) begin
        if (cnt >= ar_dly) begin m_axil_arready = 1'b1; cap_araddr = m_axil_araddr; end
        cnt++;
      end else cnt = 0;
    end
  end

  initial begin : slv_r
    int cnt;
    cnt = 0;
    m_axil_rvalid = 1'b0;
    m_axil_rdata  = '0;
    m_axil_rresp  = 2'b00;
    forever begin
      @(negedge clk);
      m_axil_rvalid = 1'b0;
      if (m_axil_rready) begin
        r_cyc++;
        if (cnt >= r_dly) begin
          m_axil_rvalid = 1'b1; m_axil_rdata = r_data_v; m_axil_rresp = r_resp_v;
        end
        cnt++;
      end else cnt = 0;
    end
  end

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = $urandom;
      req_wdata[i*DW +: DW] = $urandom;
      req_wstrb[i*SW +: SW] = SW'($urandom_range(0, 15));
      req_write[i]          = 1'($urandom_range(0, 1));
    end
    r_data_v = $urandom;
    b_resp_v = 2'($urandom_range(0, 3));
    r_resp_v = 2'($urandom_range(0, 3));
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ctl"}, 64'({req_ready, rsp_valid, m_axil_awvalid, m_axil_wvalid,
                            m_axil_bready, m_axil_arvalid, m_axil_rready}), 64'd0);
    chk({tag, "_dat"}, 64'(|{rsp_rdata, rsp_resp, m_axil_awaddr, m_axil_awprot, m_axil_wdata,
                             m_axil_wstrb, m_axil_araddr, m_axil_arprot}), 64'd0);
  endtask

  // One transaction: present vmask, check the grant, follow it to rsp_valid.
  task automatic run_txn(input logic [N-1:0] vmask, input string tag,
                         output int got, output int aw_n, output int w_n, output int r_n);
    int            w, cnt, exp_lat, aw0, w0, r0, be0;
    logic          busy_bad, exp_wr;
    logic [N-1:0]  oh;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_rd;
    logic [SW-1:0] exp_ws;
    logic [1:0]    exp_resp;
    @(negedge clk);
    chk({tag, "_rsp_pulse_end"}, 64'(rsp_valid), 64'd0);
    req_valid = vmask;
    #1;
    w  = pick(vmask, last_gnt);
    oh = '0;
    oh[w] = 1'b1;
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(oh));
    exp_wr   = req_write[w];
    exp_addr = req_addr[w*AW +: AW];
    exp_wd   = req_wdata[w*DW +: DW];
    exp_ws   = req_wstrb[w*SW +: SW];
    exp_resp = exp_wr ? b_resp_v : r_resp_v;
    exp_rd   = exp_wr ? '0 : r_data_v;
    exp_lat  = exp_wr ? max2(aw_dly, w_dly) + b_dly + 3 : ar_dly + r_dly + 3;
    aw0 = aw_cyc; w0 = w_cyc; r0 = r_cyc; be0 = b_early;
    last_gnt = w;
    @(posedge clk);
    cnt = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (req_ready !== '0) busy_bad = 1'b1;
    end while (rsp_valid === '0 && cnt < 300);
    got = -1;
    for (int i = 0; i < N; i++) if (rsp_valid[i] === 1'b1) got = i;
    chk({tag, "_busy_no_ready"}, 64'(busy_bad), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
    chk({tag, "_rsp_resp"}, 64'(rsp_resp), 64'(exp_resp));
    chk({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
    chk({tag, "_prot"}, 64'({m_axil_awprot, m_axil_arprot}), 64'd0);
    if (exp_wr) begin
      chk({tag, "_awaddr"}, 64'(cap_awaddr), 64'(exp_addr));
      chk({tag, "_wdata"}, 64'(cap_wdata), 64'(exp_wd));
      chk({tag, "_wstrb"}, 64'(cap_wstrb), 64'(exp_ws));
      chk({tag, "_bready_early"}, 64'(b_early - be0), 64'd0);
    end else begin
      chk({tag, "_araddr"}, 64'(cap_araddr), 64'(exp_addr));
    end
    aw_n = aw_cyc - aw0;
    w_n  = w_cyc - w0;
    r_n  = r_cyc - r0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   got, aw_n, w_n, r_n, cnt;
    logic rsp_seen;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    outs_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    outs_zero("after_release");

    // Test 1: zero-wait write from requester 0.
    rand_fields();
    req_write[0] = 1'b1;
    req_addr[0*AW +: AW]  = 32'h10;
    req_wdata[0*DW +: DW] = 32'hDEADBEEF;
    req_wstrb[0*SW +: SW] = 4'hF;
    b_resp_v = 2'b00;
    run_txn(3'b001, "t1_write", got, aw_n, w_n, r_n);
    chk("t1_aw_cycles", 64'(aw_n), 64'd1);
    chk("t1_w_cycles", 64'(w_n), 64'd1);

    // Test 2: read from requester 1, data after 4 wait cycles.
    rand_fields();
    req_write[1] = 1'b0;
    req_addr[1*AW +: AW] = 32'h24;
    r_data_v = 32'h12345678;
    r_resp_v = 2'b00;
    r_dly    = 4;
    run_txn(3'b010, "t2_read", got, aw_n, w_n, r_n);
    chk("t2_rready_cycles", 64'(r_n), 64'd5);
    r_dly = 0;

    // Test 3: requesters 0 and 1 held valid for six back-to-back transactions.
    req_valid = 3'b011;
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      run_txn(3'b011, "t3_rr", got, aw_n, w_n, r_n);
      chk("t3_grant_order", 64'(got), 64'(i % 2));
    end

    // Test 4: awready delayed 3 cycles, wready immediate.
    rand_fields();
    req_write[2] = 1'b1;
    aw_dly = 3;
    run_txn(3'b100, "t4_aw_slow", got, aw_n, w_n, r_n);
    chk("t4_aw_cycles", 64'(aw_n), 64'd4);
    chk("t4_w_cycles", 64'(w_n), 64'd1);
    aw_dly = 0;

    // Test 5: read error forwarded, then the next request is accepted.
    rand_fields();
    req_write[0] = 1'b0;
    r_resp_v = 2'b10;
    run_txn(3'b001, "t5_slverr", got, aw_n, w_n, r_n);
    rand_fields();
    run_txn(3'b110, "t5_next", got, aw_n, w_n, r_n);

    // Random traffic with random slave delays and response codes.
    for (int t = 0; t < 30; t++) begin
      rand_fields();
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      run_txn(N'($urandom_range(1, (1 << N) - 1)), "rnd", got, aw_n, w_n, r_n);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

    // Test 6: reset while waiting for B.
    rand_fields();
    req_write[1] = 1'b1;
    b_dly = 20;
    @(negedge clk);
    req_valid = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    cnt = 0;
    while (m_axil_bready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("t6_in_wr_resp", 64'(m_axil_bready), 64'd1);
    rst_n = 1'b0;
    #1;
    outs_zero("t6_reset");
    b_dly = 0;
    rsp_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== '0) rsp_seen = 1'b1;
    end
    rst_n = 1'b1;
    last_gnt = N - 1;
    @(negedge clk);
    if (rsp_valid !== '0) rsp_seen = 1'b1;
    chk("t6_no_rsp", 64'(rsp_seen), 64'd0);
    rand_fields();
    run_txn(3'b011, "t6_after", got, aw_n, w_n, r_n);
    chk("t6_req0_first", 64'(got), 64'd0);

    @(negedge clk);
    req_valid = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
